// File: rtl/mac_arbiter_pkg.sv
// Shared constants and operand/result types for the round-robin MAC arbiter.
// Used by mac_arbiter (optional macro MAC_ARBITER_CNT_EN), mac_pipe and mac_arbiter_if.
package mac_arb_pkg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned OUT_WIDTH = 2 * WIDTH + 1;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned ID_W      = $clog2(NUM_REQ);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [ID_W-1:0]  id;
  } mac_op_t;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [ID_W-1:0]      id;
  } mac_res_t;

endpackage

// File: rtl/mac_arbiter_if.sv
// Requester/result bundle between the processing blocks (master) and the
// MAC arbiter (slave).
interface mac_arbiter_if;
  import mac_arb_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*WIDTH-1:0] req_c;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     hold;
  logic                     res_valid;
  logic [ID_W-1:0]          res_id;
  logic [OUT_WIDTH-1:0]     res_data;
  logic                     idle;

  modport master (
    output req_valid, req_a, req_b, req_c, hold,
    input  req_ready, res_valid, res_id, res_data, idle
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, hold,
    output req_ready, res_valid, res_id, res_data, idle
  );

endinterface

// File: rtl/mac_arbiter_pipe.sv
// Three-stage A*B+C pipeline (S0 capture, S1 product, S2 sum) carrying the
// requester ID alongside; no stall, result registers hold between strobes.
module mac_pipe
  import mac_arb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  input  mac_op_t  in_op,
  output logic     out_valid,
  output mac_res_t out_res,
  output logic     busy
);

  logic                 v0;
  mac_op_t              op0;
  logic                 v1;
  logic [2*WIDTH-1:0]   prod1;
  logic [WIDTH-1:0]     c1;
  logic [ID_W-1:0]      id1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v0  <= 1'b0;
      op0 <= '0;
    end else begin
      v0 <= in_valid;
      if (in_valid) op0 <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      prod1 <= '0;
      c1    <= '0;
      id1   <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        prod1 <= (2*WIDTH)'(op0.a) * (2*WIDTH)'(op0.b);
        c1    <= op0.c;
        id1   <= op0.id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_res   <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        out_res.data <= OUT_WIDTH'(prod1) + OUT_WIDTH'(c1);
        out_res.id   <= id1;
      end
    end
  end

  assign busy = v0 | v1 | out_valid;

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin grant logic sharing one mac_pipe among NUM_REQ requesters.
// Optional MAC_ARBITER_CNT_EN adds per-requester 16-bit grant counters (grant_cnt).
module mac_arbiter
  import mac_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  mac_arbiter_if.slave           bus
`ifdef MAC_ARBITER_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]  grant_cnt
`endif
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  mac_op_t            grant_op;
  mac_res_t           res;
  logic               busy;

  // Scan from rr_ptr upward, modulo NUM_REQ; first asserted valid wins.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] sel;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (!grant_any && bus.req_valid[sel]) begin
        grant_any   = 1'b1;
        grant[sel]  = 1'b1;
        grant_id    = sel;
      end
    end
    if (bus.hold) begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
    end
  end

  always_comb begin
    grant_op    = '0;
    grant_op.a  = bus.req_a[32'(grant_id)*WIDTH +: WIDTH];
    grant_op.b  = bus.req_b[32'(grant_id)*WIDTH +: WIDTH];
    grant_op.c  = bus.req_c[32'(grant_id)*WIDTH +: WIDTH];
    grant_op.id = grant_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  mac_pipe u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (grant_any),
    .in_op     (grant_op),
    .out_valid (bus.res_valid),
    .out_res   (res),
    .busy      (busy)
  );

  assign bus.req_ready = grant;
  assign bus.res_id    = res.id;
  assign bus.res_data  = res.data;
  assign bus.idle      = ~busy;

`ifdef MAC_ARBITER_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
